latch_bank_writer: RTL

Clocked write controller for a bank of transparent latches with active-low gates, async clear and async preset. It accepts one request per handshake and converts it into glitch-free, registered strobe sequences: data setup, then a gate, clear or preset pulse, then data hold. It is the write side in front of latch-based storage built from our latch cells. The clocked logic only writes; downstream reads the latch Q outputs directly.

---
 rtl/latch_bank_writer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/latch_bank_writer.sv
// latch_bank_writer: clocked write sequencer for a bank of gated latches.
// Ports: clk, reset_n (async low); req_valid/req_ready/req_op/req_addr/req_data
// request handshake; lat_d/lat_g_n/lat_clr/lat_pre registered latch strobes;
// done/err one-cycle completion pulses (err = address out of range).
module latch_bank_writer #(
    parameter int NUM       = 8,
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_data,
    output logic [WIDTH-1:0]  lat_d,
    output logic [NUM-1:0]    lat_g_n,
    output logic [NUM-1:0]    lat_clr,
    output logic [NUM-1:0]    lat_pre,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SET_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PUL_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HLD_LD = CW'(HOLD_CYC - 1);

    // NUM fits in ADDR_W+1 bits because 2**ADDR_W >= NUM
    localparam logic [ADDR_W:0] NUM_A = (ADDR_W + 1)'(NUM);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;

    logic              addr_ok;
    logic              bad;
    logic [NUM-1:0]    hit;
    logic [NUM-1:0]    g_nx;
    logic [NUM-1:0]    clr_nx;
    logic [NUM-1:0]    pre_nx;

    assign req_ready = (state == IDLE);
    assign addr_ok   = ({1'b0, addr_q} < NUM_A);
    assign bad       = (op_q != 2'b11) && !addr_ok;
    assign hit       = addr_ok ? (NUM'(1) << addr_q) : '0;

    // Strobe pattern decoded ahead of time and loaded into the output
    // flops on the SETUP->PULSE edge, so the latch pins never see decode.
    always_comb begin
        g_nx   = '1;
        clr_nx = '0;
        pre_nx = '0;
        case (op_q)
            2'b00:   g_nx   = ~hit;
            2'b01:   clr_nx = hit;
            2'b10:   pre_nx = hit;
            default: clr_nx = '1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= 2'b00;
            addr_q  <= '0;
            lat_d   <= '0;
            lat_g_n <= '1;
            lat_clr <= '0;
            lat_pre <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state  <= SETUP;
                        cnt    <= SET_LD;
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        if (req_op == 2'b00) begin
                            lat_d <= req_data;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state   <= PULSE;
                        cnt     <= PUL_LD;
                        lat_g_n <= g_nx;
                        lat_clr <= clr_nx;
                        lat_pre <= pre_nx;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= HLD_LD;
                        lat_g_n <= '1;
                        lat_clr <= '0;
                        lat_pre <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        err   <= bad;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
